mio_if_stream: RTL and testbench

Receive-side MIO-to-emesh interface with multi-beat serialisation. It sits between the MIO rx FIFO and the core.
- Normal mode: each MPW-bit rx packet is forwarded as one emesh packet.
- Auto-address mode (amode): each rx packet is unpacked into MPW/(8*datasize) emesh write transactions, with an auto-incrementing destination address.
- Output is registered, with wait back-pressure in both directions.

---
 rtl/mio_pkg.sv | 30 +++
 rtl/emesh2packet.sv | 15 +
 rtl/mio_lane_sel.sv | 28 ++
 rtl/packet2emesh.sv | 20 ++
 rtl/mio_if_stream.sv | 170 +++++++++++++++++
 tb/tb_mio_if_stream.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/mio_pkg.sv
// Shared types and helpers for the MIO receive stream interface.
package mio_pkg;

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    // Unsupported beat sizes fall back to 8 bytes.
    function automatic logic [3:0] norm_dsize(input logic [3:0] ds);
        case (ds)
            4'd1, 4'd2, 4'd4: return ds;
            default:          return 4'd8;
        endcase
    endfunction

    function automatic logic [1:0] dsize2mode(input logic [3:0] ds);
        case (ds)
            4'd1:    return 2'b00;
            4'd2:    return 2'b01;
            4'd4:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int unsigned lane_count(input int unsigned mpw, input logic [3:0] ds);
        return mpw / (32'd8 * 32'(ds));
    endfunction

endpackage

// File: rtl/emesh2packet.sv
// Packs emesh transaction fields into a flat emesh packet.
module emesh2packet #(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic          i_write,
    input  logic [1:0]    i_datamode,
    input  logic [4:0]    i_ctrlmode,
    input  logic [AW-1:0] i_dstaddr,
    input  logic [AW-1:0] i_data,
    input  logic [AW-1:0] i_srcaddr,
    output logic [PW-1:0] o_packet
);
    assign o_packet = {i_srcaddr, i_data, i_dstaddr, i_ctrlmode, i_datamode, i_write};
endmodule

// File: rtl/mio_lane_sel.sv
// Picks one amode beat lane out of a buffered MIO packet, zero-extended to 64 bits.
module mio_lane_sel
    import mio_pkg::*;
#(
    parameter int MPW = 128,
    parameter int CW  = 4
) (
    input  logic [MPW-1:0] i_buf,
    input  logic [3:0]     i_dsize,
    input  logic           i_lsbfirst,
    input  logic [CW-1:0]  i_idx,
    output logic [63:0]    o_lane
);
    logic [CW-1:0]  w_lane_num;
    logic [MPW-1:0] w_shifted;

    always_comb begin
        // i_idx is the beat number; msb-first walks lanes from the top down.
        w_lane_num = i_lsbfirst ? i_idx : CW'(lane_count(MPW, i_dsize) - 1) - i_idx;
        w_shifted  = i_buf >> (32'(w_lane_num) * 32'(i_dsize) * 32'd8);
        case (i_dsize)
            4'd1:    o_lane = {56'd0, w_shifted[7:0]};
            4'd2:    o_lane = {48'd0, w_shifted[15:0]};
            4'd4:    o_lane = {32'd0, w_shifted[31:0]};
            default: o_lane = w_shifted[63:0];
        endcase
    end
endmodule

// File: rtl/packet2emesh.sv
// Splits an emesh packet into its transaction fields.
module packet2emesh #(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic [PW-1:0] i_packet,
    output logic          o_write,
    output logic [1:0]    o_datamode,
    output logic [4:0]    o_ctrlmode,
    output logic [AW-1:0] o_dstaddr,
    output logic [AW-1:0] o_data,
    output logic [AW-1:0] o_srcaddr
);
    assign o_write    = i_packet[0];
    assign o_datamode = i_packet[2:1];
    assign o_ctrlmode = i_packet[7:3];
    assign o_dstaddr  = i_packet[8 +: AW];
    assign o_data     = i_packet[8+AW +: AW];
    assign o_srcaddr  = i_packet[8+2*AW +: AW];
endmodule

// File: rtl/mio_if_stream.sv
// MIO rx to emesh bridge: forwards packets unchanged, or in amode splits each packet
// into auto-addressed write beats.
module mio_if_stream
    import mio_pkg::*;
#(
    parameter int AW  = 32,
    parameter int PW  = 104,
    parameter int MPW = 128
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           amode,
    input  logic           lsbfirst,
    input  logic [3:0]     datasize,
    input  logic [4:0]     ctrlmode,
    input  logic [AW-1:0]  dstaddr,
    input  logic           addr_load,
    output logic           access_out,
    output logic [PW-1:0]  packet_out,
    input  logic           wait_in,
    input  logic           rx_access_in,
    input  logic [MPW-1:0] rx_packet_in,
    output logic           rx_wait_out
);
    localparam int CW = $clog2(MPW / 8);

    state_t         r_state, w_state_d;
    logic           r_access;
    logic [PW-1:0]  r_packet;
    logic [CW-1:0]  r_cnt;
    logic [MPW-1:0] r_buf;
    logic [3:0]     r_dsize;
    logic           r_lsbfirst;
    logic [4:0]     r_ctrlmode;
    logic [AW-1:0]  r_addr;
    logic           r_amode_prev;

    logic           w_stall, w_more, w_accept, w_load, w_issue_amode, w_normal, w_multi;
    logic [3:0]     w_in_dsize, w_dsize;
    logic [CW-1:0]  w_idx, w_first_cnt;
    logic [MPW-1:0] w_buf_src;
    logic [63:0]    w_lane;
    logic [AW-1:0]  w_addr_d;
    logic [PW-1:0]  w_packet_d;

    logic           w_rx_write, w_write;
    logic [1:0]     w_rx_datamode, w_datamode;
    logic [4:0]     w_rx_ctrlmode, w_ctrlmode;
    logic [AW-1:0]  w_rx_dstaddr, w_rx_data, w_rx_srcaddr;
    logic [AW-1:0]  w_dstaddr, w_data, w_srcaddr;

    assign w_stall     = r_access & wait_in;
    assign w_more      = (r_cnt != '0);
    assign rx_wait_out = w_stall | w_more;
    assign w_accept    = rx_access_in & ~rx_wait_out;
    assign w_load      = ~w_stall & (w_accept | w_more);
    assign w_normal    = w_accept & ~amode;
    // Beats loaded while draining the buffer are always amode beats.
    assign w_issue_amode = w_load & (w_accept ? amode : 1'b1);

    assign w_in_dsize  = norm_dsize(datasize);
    assign w_dsize     = w_accept ? w_in_dsize : r_dsize;
    assign w_first_cnt = CW'(lane_count(MPW, w_in_dsize) - 1);
    assign w_multi     = w_accept & amode & (lane_count(MPW, w_in_dsize) > 1);
    assign w_idx       = w_accept ? '0 : CW'(lane_count(MPW, r_dsize)) - r_cnt;
    assign w_buf_src   = w_accept ? rx_packet_in : r_buf;

    assign w_addr_d = (addr_load | (amode & ~r_amode_prev)) ? dstaddr :
                      w_issue_amode ? r_addr + AW'(w_dsize) : r_addr;

    assign access_out = r_access;
    assign packet_out = r_packet;

    mio_lane_sel #(
        .MPW (MPW),
        .CW  (CW)
    ) u_lane_sel (
        .i_buf      (w_buf_src),
        .i_dsize    (w_dsize),
        .i_lsbfirst (w_accept ? lsbfirst : r_lsbfirst),
        .i_idx      (w_idx),
        .o_lane     (w_lane)
    );

    packet2emesh #(
        .AW (AW),
        .PW (PW)
    ) u_p2e (
        .i_packet   (rx_packet_in[PW-1:0]),
        .o_write    (w_rx_write),
        .o_datamode (w_rx_datamode),
        .o_ctrlmode (w_rx_ctrlmode),
        .o_dstaddr  (w_rx_dstaddr),
        .o_data     (w_rx_data),
        .o_srcaddr  (w_rx_srcaddr)
    );

    always_comb begin
        w_write    = 1'b1;
        w_datamode = dsize2mode(w_dsize);
        w_ctrlmode = w_accept ? ctrlmode : r_ctrlmode;
        w_dstaddr  = r_addr;
        w_data     = w_lane[AW-1:0];
        w_srcaddr  = (w_dsize == 4'd8) ? w_lane[2*AW-1:AW] : '0;
        if (w_normal) begin
            w_write    = w_rx_write;
            w_datamode = w_rx_datamode;
            w_ctrlmode = w_rx_ctrlmode;
            w_dstaddr  = w_rx_dstaddr;
            w_data     = w_rx_data;
            w_srcaddr  = w_rx_srcaddr;
        end
    end

    emesh2packet #(
        .AW (AW),
        .PW (PW)
    ) u_e2p (
        .i_write    (w_write),
        .i_datamode (w_datamode),
        .i_ctrlmode (w_ctrlmode),
        .i_dstaddr  (w_dstaddr),
        .i_data     (w_data),
        .i_srcaddr  (w_srcaddr),
        .o_packet   (w_packet_d)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_multi) w_state_d = StSend;
            StSend:  if (~w_stall & ~w_more & ~w_multi) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= StIdle;
            r_access     <= 1'b0;
            r_packet     <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_dsize      <= 4'd8;
            r_lsbfirst   <= 1'b0;
            r_ctrlmode   <= '0;
            r_addr       <= '0;
            r_amode_prev <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_amode_prev <= amode;
            r_addr       <= w_addr_d;
            if (w_load) begin
                r_access <= 1'b1;
                r_packet <= w_packet_d;
            end else if (!w_stall) begin
                r_access <= 1'b0;
            end
            if (w_accept) begin
                r_buf      <= rx_packet_in;
                r_dsize    <= w_in_dsize;
                r_lsbfirst <= lsbfirst;
                r_ctrlmode <= ctrlmode;
                r_cnt      <= amode ? w_first_cnt : '0;
            end else if (w_load) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mio_if_stream.sv
// Directed plus randomized bench for mio_if_stream against a queue-based beat model.
module tb_mio_if_stream;
    localparam int AW  = 32;
    localparam int PW  = 104;
    localparam int MPW = 128;

    logic           clk = 1'b0;
    logic           nreset, amode, lsbfirst, addr_load, wait_in, rx_access_in;
    logic [3:0]     datasize;
    logic [4:0]     ctrlmode;
    logic [AW-1:0]  dstaddr;
    logic [MPW-1:0] rx_packet_in;
    logic           access_out, rx_wait_out;
    logic [PW-1:0]  packet_out;

    always #5 clk = ~clk;

    mio_if_stream #(
        .AW  (AW),
        .PW  (PW),
        .MPW (MPW)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .amode        (amode),
        .lsbfirst     (lsbfirst),
        .datasize     (datasize),
        .ctrlmode     (ctrlmode),
        .dstaddr      (dstaddr),
        .addr_load    (addr_load),
        .access_out   (access_out),
        .packet_out   (packet_out),
        .wait_in      (wait_in),
        .rx_access_in (rx_access_in),
        .rx_packet_in (rx_packet_in),
        .rx_wait_out  (rx_wait_out)
    );

    typedef struct {
        logic          is_amode;
        logic [3:0]    ds;
        logic [PW-1:0] pkt;
    } beat_t;

    beat_t         q[$];
    logic          exp_access;
    logic [PW-1:0] exp_packet;
    logic [AW-1:0] m_addr;
    logic          m_prev_amode;
    int            n_total, n_pass, n_fail;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expand an accepted rx packet into the beats it should produce (address filled at issue).
    task automatic push_packet();
        beat_t       b;
        logic [3:0]  ds;
        logic [1:0]  dm;
        logic [63:0] v;
        int          n, lw, lane;
        if (!amode) begin
            b.is_amode = 1'b0;
            b.ds       = 4'd0;
            b.pkt      = rx_packet_in[PW-1:0];
            q.push_back(b);
        end else begin
            ds = (datasize == 4'd1 || datasize == 4'd2 || datasize == 4'd4) ? datasize : 4'd8;
            lw = 8 * int'(ds);
            n  = MPW / lw;
            dm = (ds == 4'd1) ? 2'b00 : (ds == 4'd2) ? 2'b01 : (ds == 4'd4) ? 2'b10 : 2'b11;
            for (int k = 0; k < n; k++) begin
                lane = lsbfirst ? k : n - 1 - k;
                v = 64'(rx_packet_in >> (lane * lw));
                if (lw < 64) v = v & ((64'd1 << lw) - 64'd1);
                b.is_amode = 1'b1;
                b.ds       = ds;
                if (ds == 4'd8) b.pkt = {v[63:32], v[31:0], 32'h0, ctrlmode, dm, 1'b1};
                else            b.pkt = {32'h0, v[31:0], 32'h0, ctrlmode, dm, 1'b1};
                q.push_back(b);
            end
        end
    endtask

    // One clock: check rx_wait_out, advance the model over the edge, check the outputs.
    task automatic tick();
        logic  stall, exp_wait, acc;
        beat_t b;
        #1;
        stall    = exp_access & wait_in;
        exp_wait = stall | (q.size() != 0);
        chk("rx_wait_out", PW'(rx_wait_out), PW'(exp_wait));
        acc = rx_access_in & ~exp_wait;
        if (!stall) begin
            if (acc) push_packet();
            if (q.size() != 0) begin
                b          = q.pop_front();
                exp_access = 1'b1;
                exp_packet = b.pkt;
                if (b.is_amode) begin
                    exp_packet[8 +: AW] = m_addr;
                    m_addr = m_addr + AW'(b.ds);
                end
            end else begin
                exp_access = 1'b0;
            end
        end
        if (addr_load || (amode && !m_prev_amode)) m_addr = dstaddr;
        m_prev_amode = amode;
        @(posedge clk);
        #1;
        chk("access_out", PW'(access_out), PW'(exp_access));
        if (exp_access) chk("packet_out", packet_out, exp_packet);
    endtask

    task automatic model_reset();
        q.delete();
        exp_access   = 1'b0;
        exp_packet   = '0;
        m_addr       = '0;
        m_prev_amode = 1'b0;
    endtask

    function automatic logic [MPW-1:0] rnd_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        nreset = 1'b0; amode = 1'b0; lsbfirst = 1'b0; datasize = 4'd0; ctrlmode = '0;
        dstaddr = '0; addr_load = 1'b0; wait_in = 1'b0; rx_access_in = 1'b0; rx_packet_in = '0;
        model_reset();
        #3;
        chk("reset access_out", PW'(access_out), PW'(1'b0));
        chk("reset packet_out", packet_out, '0);
        chk("reset rx_wait_out", PW'(rx_wait_out), PW'(1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 nreset = 1'b1;
        tick();

        // Normal mode, three back-to-back packets.
        for (int i = 0; i < 3; i++) begin
            rx_access_in = 1'b1;
            rx_packet_in = rnd_pkt();
            tick();
        end
        rx_access_in = 1'b0;
        tick();
        tick();

        // Amode, 4-byte lanes, lsb first.
        amode = 1'b1; datasize = 4'd4; lsbfirst = 1'b1; ctrlmode = 5'h0a;
        dstaddr = 32'h8000_0000;
        tick();
        rx_access_in = 1'b1;
        rx_packet_in = 128'h44444444_33333333_22222222_11111111;
        tick();
        rx_access_in = 1'b0;
        chk("amode4 b0 data", PW'(packet_out[71:40]), PW'(32'h1111_1111));
        chk("amode4 b0 addr", PW'(packet_out[39:8]), PW'(32'h8000_0000));
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("amode4 data", PW'(packet_out[71:40]), PW'(32'h1111_1111 * (k + 1)));
            chk("amode4 addr", PW'(packet_out[39:8]), PW'(32'h8000_0000 + 4 * k));
        end
        tick();
        tick();

        // Amode, 8-byte lanes, msb first.
        datasize = 4'd8; lsbfirst = 1'b0;
        rx_access_in = 1'b1;
        rx_packet_in = rnd_pkt();
        tick();
        rx_access_in = 1'b0;
        chk("amode8 data", PW'(packet_out[71:40]), PW'(rx_packet_in[95:64]));
        chk("amode8 srcaddr", PW'(packet_out[103:72]), PW'(rx_packet_in[127:96]));
        chk("amode8 datamode", PW'(packet_out[2:1]), PW'(2'b11));
        chk("amode8 addr0", PW'(packet_out[39:8]), PW'(32'h8000_0010));
        tick();
        chk("amode8 addr1", PW'(packet_out[39:8]), PW'(32'h8000_0018));
        tick();
        tick();

        // Back-pressure for five cycles on beat 2 of 4.
        datasize = 4'd4; lsbfirst = 1'b1;
        rx_access_in = 1'b1;
        rx_packet_in = rnd_pkt();
        tick();
        rx_access_in = 1'b0;
        tick();
        wait_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        wait_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Address wrap, then a mid-packet reload.
        dstaddr = 32'hFFFF_FFFC; addr_load = 1'b1;
        tick();
        addr_load = 1'b0;
        rx_access_in = 1'b1;
        rx_packet_in = rnd_pkt();
        tick();
        chk("wrap addr0", PW'(packet_out[39:8]), PW'(32'hFFFF_FFFC));
        tick();
        chk("wrap addr1", PW'(packet_out[39:8]), PW'(32'h0000_0000));
        tick();
        tick();
        tick();
        rx_access_in = 1'b0;
        dstaddr = 32'h0000_0100; addr_load = 1'b1;
        tick();
        addr_load = 1'b0;
        tick();
        chk("reload addr", PW'(packet_out[39:8]), PW'(32'h0000_0100));
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic with mode changes, reloads and back-pressure.
        for (int i = 0; i < 120; i++) begin
            rx_access_in = ($urandom_range(0, 3) != 0);
            wait_in      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) amode = ~amode;
            datasize     = 4'($urandom_range(0, 15));
            lsbfirst     = 1'($urandom);
            ctrlmode     = 5'($urandom);
            addr_load    = ($urandom_range(0, 15) == 0);
            dstaddr      = $urandom;
            rx_packet_in = rnd_pkt();
            tick();
        end
        rx_access_in = 1'b0; wait_in = 1'b0; addr_load = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Reset during beat 2 of 4, then a fresh packet with an unsupported size.
        amode = 1'b1; datasize = 4'd4; lsbfirst = 1'b1; dstaddr = 32'h0000_2000;
        addr_load = 1'b1;
        tick();
        addr_load = 1'b0;
        rx_access_in = 1'b1;
        rx_packet_in = rnd_pkt();
        tick();
        rx_access_in = 1'b0;
        tick();
        #2 nreset = 1'b0;
        #1;
        chk("midreset access_out", PW'(access_out), PW'(1'b0));
        chk("midreset packet_out", packet_out, '0);
        chk("midreset rx_wait_out", PW'(rx_wait_out), PW'(1'b0));
        model_reset();
        @(posedge clk);
        #1 nreset = 1'b1;
        tick();
        datasize = 4'd3;
        rx_access_in = 1'b1;
        rx_packet_in = rnd_pkt();
        tick();
        rx_access_in = 1'b0;
        chk("size3 datamode", PW'(packet_out[2:1]), PW'(2'b11));
        chk("size3 addr0", PW'(packet_out[39:8]), PW'(32'h0000_2000));
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
